// File: rtl/capture_readback_pkg.sv
// Shared definitions for the capture buffer read-side engine: buffer depth,
// length width and FSM state encodings.
package capture_readback_pkg;

  localparam int CAP_DEPTH = 65536;
  localparam int CAP_LEN_W = 17;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REWIND = 2'd1;
  localparam logic [1:0] ST_FETCH  = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

endpackage

// File: rtl/cap_bit_packer.sv
// Serial-to-parallel bit packer with a valid/ready output holding register.
// Bits enter MSB-first; a completed (or final, left-justified) word moves
// straight to the output register when it is free, otherwise it parks in the
// packer until the host takes the current word.
module cap_bit_packer
  import capture_readback_pkg::*;
#(
  parameter  int WORD_W = 8,
  localparam int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              bit_in,
  input  logic              bit_vld,
  input  logic              bit_last,
  output logic [CNT_W-1:0]  fill_next,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  logic [WORD_W-1:0] sh, sh_n, shifted, justified, load_data;
  logic [CNT_W-1:0]  cnt, cnt_n, shamt;
  logic              pend, pend_n, pend_last, pend_last_n;
  logic              load, load_last, out_free, complete;

  // Next-state of the packer and the word (if any) handed to the output register
  always_comb begin
    out_free    = !out_valid || out_ready;
    shifted     = {sh[WORD_W-2:0], bit_in};
    shamt       = CNT_W'(WORD_W - 1) - cnt;
    justified   = shifted << shamt;
    complete    = bit_vld && (bit_last || (cnt == CNT_W'(WORD_W - 1)));
    sh_n        = sh;
    cnt_n       = cnt;
    pend_n      = pend;
    pend_last_n = pend_last;
    load        = 1'b0;
    load_data   = sh;
    load_last   = pend_last;
    if (pend) begin
      // A parked word already holds WORD_W bits' worth of room; nothing else is in flight.
      if (out_free) begin
        load   = 1'b1;
        pend_n = 1'b0;
        cnt_n  = '0;
        sh_n   = '0;
      end
    end else if (bit_vld) begin
      if (complete) begin
        if (out_free) begin
          load      = 1'b1;
          load_data = justified;
          load_last = bit_last;
          cnt_n     = '0;
          sh_n      = '0;
        end else begin
          pend_n      = 1'b1;
          pend_last_n = bit_last;
          sh_n        = justified;
          cnt_n       = CNT_W'(WORD_W);
        end
      end else begin
        sh_n  = shifted;
        cnt_n = cnt + CNT_W'(1);
      end
    end
  end

  // Occupancy after this cycle, used upstream to gate new reads
  assign fill_next = cnt_n;

  // Packer state and output holding register
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      sh        <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      sh        <= sh_n;
      cnt       <= cnt_n;
      pend      <= pend_n;
      pend_last <= pend_last_n;
      if (load) begin
        out_data  <= load_data;
        out_last  <= load_last;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/capture_readback.sv
// Read-side engine for the 64K x 1 ADC capture buffer: rewinds the buffer,
// issues LEN single-bit reads and streams them out packed MSB-first.
module capture_readback
  import capture_readback_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int RD_LAT = 1,
  parameter int LEN_W  = CAP_LEN_W
) (
  input  logic              rdclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_rewind,
  output logic              rd_en,
  input  logic              rd_data,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  logic [1:0]       state;
  logic [LEN_W-1:0] remaining;
  logic [RD_LAT-1:0] vld_pipe, lst_pipe;
  logic [CNT_W-1:0] fill_next;
  logic             tap_vld, tap_last, fetch_room, last_accept;
  int               occ;

  // Requests longer than the buffer read the whole buffer once
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l > LEN_W'(CAP_DEPTH)) return LEN_W'(CAP_DEPTH);
    return l;
  endfunction

  assign tap_vld     = vld_pipe[RD_LAT-1];
  assign tap_last    = lst_pipe[RD_LAT-1];
  assign busy        = (state != ST_IDLE);
  assign rd_rewind   = (state == ST_REWIND);
  assign last_accept = out_valid && out_ready && out_last;

  // Bits the packer will hold next cycle plus reads still travelling after this cycle
  always_comb begin
    occ = int'(fill_next);
    for (int i = 0; i < RD_LAT - 1; i++) begin
      occ = occ + (vld_pipe[i] ? 1 : 0);
    end
    fetch_room = (occ < WORD_W);
  end

  assign rd_en = (state == ST_FETCH) && (remaining != '0) && fetch_room && !abort;

  // Control FSM, read counter and read-latency valid/last pipe
  always_ff @(posedge rdclk) begin
    if (!rst_n || abort) begin
      state     <= ST_IDLE;
      remaining <= '0;
      done      <= 1'b0;
      vld_pipe  <= '0;
      lst_pipe  <= '0;
    end else begin
      done        <= 1'b0;
      vld_pipe[0] <= rd_en;
      lst_pipe[0] <= rd_en && (remaining == LEN_W'(1));
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        lst_pipe[i] <= lst_pipe[i-1];
      end
      if (rd_en) remaining <= remaining - LEN_W'(1);
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              remaining <= clamp_len(len);
              state     <= ST_REWIND;
            end
          end
        end
        ST_REWIND: state <= ST_FETCH;
        ST_FETCH:  if (rd_en && (remaining == LEN_W'(1))) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (last_accept) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default:   state <= ST_IDLE;
      endcase
    end
  end

  cap_bit_packer #(.WORD_W(WORD_W)) u_packer (
    .clk       (rdclk),
    .rst_n     (rst_n),
    .flush     (abort),
    .bit_in    (rd_data),
    .bit_vld   (tap_vld),
    .bit_last  (tap_last),
    .fill_next (fill_next),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

endmodule
